// File: rtl/cipher_iter.sv
// Iterative AES forward cipher. It runs one full round per clock, taking its
// round keys from an externally supplied expanded key schedule.
//
// Handshake: raise cs with a valid Nr to start. Keep cs high until flag rises,
// and keep it high for as long as the result is needed. Drop cs for at least
// one edge to clear flag or to abort a run. While flag is high, Encrypted_Msg
// holds a valid result.
module cipher_iter #(
    parameter int MAX_NR  = 14,
    parameter int W_WIDTH = 1920
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs,
    input  logic [3:0]         Nr,
    input  logic [127:0]       init,
    input  logic [W_WIDTH-1:0] w,
    output logic [127:0]       Encrypted_Msg,
    output logic               flag
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   nr_q;
    logic [3:0]   rnd_q;
    logic [127:0] state_q;
    logic         nr_ok;
    logic         last;
    logic [127:0] rk [0:MAX_NR];

    // Slice the flat key schedule into per-round 128-bit keys.
    for (genvar r = 0; r <= MAX_NR; r++) begin : g_rk
        assign rk[r] = w[W_WIDTH-1-128*r -: 128];
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows. Byte index is row + 4*column.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = SBOX[s[127-8*(r+4*((c+r)%4)) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    assign nr_ok = (Nr == 4'd10) || (Nr == 4'd12) || (Nr == 4'd14);
    assign last  = (rnd_q == nr_q);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    // Next-state logic: start on cs with a legal Nr, abort or clear on cs low.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (cs && nr_ok) fsm_d = ROUND;
            ROUND:   if (!cs) fsm_d = IDLE;
                     else if (last) fsm_d = DONE;
            DONE:    if (!cs) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Round datapath: initial AddRoundKey, full rounds, then the final round without MixColumns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nr_q          <= '0;
            rnd_q         <= '0;
            state_q       <= '0;
            Encrypted_Msg <= '0;
            flag          <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (cs && nr_ok) begin
                        nr_q    <= Nr;
                        state_q <= init ^ rk[0];
                        rnd_q   <= 4'd1;
                    end
                end
                ROUND: begin
                    if (!cs) begin
                        state_q <= '0;
                        rnd_q   <= '0;
                    end else if (!last) begin
                        state_q <= mix_columns(sub_shift(state_q)) ^ rk[rnd_q];
                        rnd_q   <= rnd_q + 4'd1;
                    end else begin
                        Encrypted_Msg <= sub_shift(state_q) ^ rk[nr_q];
                        flag          <= 1'b1;
                    end
                end
                DONE: begin
                    if (!cs) begin
                        flag  <= 1'b0;
                        rnd_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
